// File: rtl/booth8_prep_stage.sv
// Radix-8 Booth digit prep stage: encodes mx into per-group one-hot digits,
// precomputes 3*my, and buffers entries in a 2-deep in-order skid buffer.
// Optional: define BOOTH8_PREP_ZERO_FLAG_EN to add the out_zero port.
module booth8_prep_stage #(
  parameter int WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    mx,
  input  logic [WIDTH-1:0]    my,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(WIDTH>>2):0] s,
  output logic [(WIDTH>>2):0] d,
  output logic [(WIDTH>>2):0] t,
  output logic [(WIDTH>>2):0] q,
  output logic [(WIDTH>>2):0] n,
  output logic [WIDTH-1:0]    my_o,
`ifdef BOOTH8_PREP_ZERO_FLAG_EN
  output logic                out_zero,
`endif
  output logic [WIDTH+1:0]    tmy
);

  localparam int GROUPS = (WIDTH >> 2) + 1;
  localparam int XW     = 3 * GROUPS + 1;

  typedef struct packed {
    logic [GROUPS-1:0] s;
    logic [GROUPS-1:0] d;
    logic [GROUPS-1:0] t;
    logic [GROUPS-1:0] q;
    logic [GROUPS-1:0] n;
    logic [WIDTH-1:0]  my;
    logic [WIDTH+1:0]  tmy;
`ifdef BOOTH8_PREP_ZERO_FLAG_EN
    logic              zero;
`endif
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t        state_q;
  entry_t        enc_d;
  entry_t        head_q;
  entry_t        skid_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [XW-1:0] x_ext;
  logic [3:0]    win;
  logic          push;
  logic          pop;

  // x_ext[0] is the implicit x[-1]; bit i+1 holds x[i], zero above mx.
  always_comb begin
    enc_d = '0;
    win   = '0;
    x_ext = {{(XW-WIDTH-1){1'b0}}, mx, 1'b0};
    for (int k = 0; k < GROUPS; k++) begin
      win = x_ext[3*k +: 4];
      case (win)
        4'b0001, 4'b0010: enc_d.s[k] = 1'b1;
        4'b1101, 4'b1110: begin enc_d.s[k] = 1'b1; enc_d.n[k] = 1'b1; end
        4'b0011, 4'b0100: enc_d.d[k] = 1'b1;
        4'b1011, 4'b1100: begin enc_d.d[k] = 1'b1; enc_d.n[k] = 1'b1; end
        4'b0101, 4'b0110: enc_d.t[k] = 1'b1;
        4'b1001, 4'b1010: begin enc_d.t[k] = 1'b1; enc_d.n[k] = 1'b1; end
        4'b0111:          enc_d.q[k] = 1'b1;
        4'b1000:          begin enc_d.q[k] = 1'b1; enc_d.n[k] = 1'b1; end
        default:          ;
      endcase
    end
    enc_d.my  = my;
    enc_d.tmy = {2'b00, my} + {1'b0, my, 1'b0};
`ifdef BOOTH8_PREP_ZERO_FLAG_EN
    enc_d.zero = (mx == '0) || (my == '0);
`endif
  end

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // head_q drives the outputs directly; skid_q only fills while head stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (push) begin
            head_q      <= enc_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              skid_q     <= enc_d;
              in_ready_q <= 1'b0;
              state_q    <= FULL;
            end
            2'b01: begin
              out_valid_q <= 1'b0;
              state_q     <= EMPTY;
            end
            2'b11:   head_q <= enc_d;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = head_q.s;
  assign d         = head_q.d;
  assign t         = head_q.t;
  assign q         = head_q.q;
  assign n         = head_q.n;
  assign my_o      = head_q.my;
  assign tmy       = head_q.tmy;
`ifdef BOOTH8_PREP_ZERO_FLAG_EN
  assign out_zero  = head_q.zero;
`endif

endmodule

// File: tb/tb_booth8_prep_stage.sv
// Self-checking bench for booth8_prep_stage: fixed vectors, 3*my sweep,
// skid/reset sequences and a randomized run against a queue-based model.
module tb_booth8_prep_stage;

  logic       CLK = 1'b0;
  logic       RST;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mx;
  logic [7:0] my;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] s, d, t, q, n;
  logic [7:0] my_o;
  logic [9:0] tmy;
`ifdef BOOTH8_PREP_ZERO_FLAG_EN
  logic       out_zero;
`endif

  booth8_prep_stage #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .mx(mx), .my(my),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .d(d), .t(t), .q(q), .n(n),
    .my_o(my_o),
`ifdef BOOTH8_PREP_ZERO_FLAG_EN
    .out_zero(out_zero),
`endif
    .tmy(tmy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] mx;
    logic [7:0] my;
    logic [2:0] s, d, t, q, n;
    logic [9:0] tmy;
    logic       zero;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[8];
  vec_t mq[$];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int xb(input logic [7:0] a, input int i);
    if (i < 0 || i > 7) return 0;
    return int'(a[i]);
  endfunction

  // Digits straight from D_k = -4*x[3k+2] + 2*x[3k+1] + x[3k] + x[3k-1].
  function automatic vec_t ref_model(input logic [7:0] a, input logic [7:0] b);
    vec_t r;
    int dig, mag;
    r.mx = a; r.my = b;
    r.s = '0; r.d = '0; r.t = '0; r.q = '0; r.n = '0;
    for (int k = 0; k < 3; k++) begin
      dig = -4*xb(a, 3*k+2) + 2*xb(a, 3*k+1) + xb(a, 3*k) + xb(a, 3*k-1);
      mag = (dig < 0) ? -dig : dig;
      r.s[k] = (mag == 1);
      r.d[k] = (mag == 2);
      r.t[k] = (mag == 3);
      r.q[k] = (mag == 4);
      r.n[k] = (dig < 0);
    end
    r.tmy  = 10'(3 * int'(b));
    r.zero = (a == 8'h00) || (b == 8'h00);
    return r;
  endfunction

  function automatic int decode();
    int sum = 0, mag, w = 1;
    for (int k = 0; k < 3; k++) begin
      mag = s[k] ? 1 : d[k] ? 2 : t[k] ? 3 : q[k] ? 4 : 0;
      sum += (n[k] ? -mag : mag) * w;
      w *= 8;
    end
    return sum;
  endfunction

  task automatic check_out(input string tag, input vec_t e);
    chk({tag, ".s"}, s, e.s);
    chk({tag, ".d"}, d, e.d);
    chk({tag, ".t"}, t, e.t);
    chk({tag, ".q"}, q, e.q);
    chk({tag, ".n"}, n, e.n);
    chk({tag, ".my_o"}, my_o, e.my);
    chk({tag, ".tmy"}, tmy, e.tmy);
`ifdef BOOTH8_PREP_ZERO_FLAG_EN
    chk({tag, ".out_zero"}, out_zero, e.zero);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".in_ready"}, in_ready, 0);
    chk({tag, ".digits"}, {s, d, t, q, n}, 0);
    chk({tag, ".my_o"}, my_o, 0);
    chk({tag, ".tmy"}, tmy, 0);
`ifdef BOOTH8_PREP_ZERO_FLAG_EN
    chk({tag, ".out_zero"}, out_zero, 0);
`endif
  endtask

  initial begin
    int acc, cyc;
    bit can_push;
    vec_t ea;

    //           mx     my     s       d       t       q       n       tmy     zero
    vecs[0] = '{8'hFF, 8'h05, 3'b001, 3'b000, 3'b000, 3'b100, 3'b001, 10'd15,  1'b0};
    vecs[1] = '{8'h03, 8'h12, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 10'd54,  1'b0};
    vecs[2] = '{8'h80, 8'h01, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 10'd3,   1'b0};
    vecs[3] = '{8'h00, 8'h07, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 10'd21,  1'b1};
    vecs[4] = '{8'h55, 8'hFF, 3'b100, 3'b000, 3'b011, 3'b000, 3'b001, 10'h2FD, 1'b0};
    vecs[5] = '{8'hAA, 8'h00, 3'b000, 3'b001, 3'b110, 3'b000, 3'b010, 10'd0,   1'b1};
    vecs[6] = '{8'h7F, 8'h80, 3'b001, 3'b100, 3'b000, 3'b000, 3'b001, 10'h180, 1'b0};
    vecs[7] = '{8'h24, 8'h55, 3'b100, 3'b000, 3'b010, 3'b001, 3'b011, 10'hFF,  1'b0};

    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mx = '0; my = '0;
    step(); step();
    check_zero("reset");
    RST = 1'b0;
    step();
    chk("reset.release.in_ready", in_ready, 1);
    chk("reset.release.out_valid", out_valid, 0);

    // Fixed vectors, each pushed from EMPTY and popped immediately.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; mx = vecs[i].mx; my = vecs[i].my; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d.out_valid", i), out_valid, 1);
      check_out($sformatf("vec%0d", i), vecs[i]);
      step();
      chk($sformatf("vec%0d.empty", i), out_valid, 0);
      chk($sformatf("vec%0d.hold_my", i), my_o, vecs[i].my);
    end

    // All 256 my values streamed back to back.
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; mx = 8'(i); my = 8'(i); out_ready = 1'b1;
      step();
      chk("sweep.tmy", tmy, 3 * i);
      chk("sweep.my_o", my_o, i);
      chk("sweep.out_valid", out_valid, 1);
      chk("sweep.in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("sweep.drained", out_valid, 0);

    // Skid: A, B accepted, C held off, then drained in order.
    out_ready = 1'b0;
    in_valid = 1'b1; mx = 8'h0A; my = 8'h11;
    step();
    chk("skid.A.in_ready", in_ready, 1);
    chk("skid.A.my_o", my_o, 8'h11);
    mx = 8'h0B; my = 8'h22;
    step();
    chk("skid.B.in_ready", in_ready, 0);
    chk("skid.B.my_o", my_o, 8'h11);
    mx = 8'h0C; my = 8'h33;
    step();
    chk("skid.C.in_ready", in_ready, 0);
    check_out("skid.stall1", ref_model(8'h0A, 8'h11));
    step();
    chk("skid.stall2.out_valid", out_valid, 1);
    check_out("skid.stall2", ref_model(8'h0A, 8'h11));
    out_ready = 1'b1;
    step();
    chk("skid.rel1.out_valid", out_valid, 1);
    check_out("skid.rel1", ref_model(8'h0B, 8'h22));
    chk("skid.rel1.in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("skid.rel2.out_valid", out_valid, 1);
    check_out("skid.rel2", ref_model(8'h0C, 8'h33));
    step();
    chk("skid.done.out_valid", out_valid, 0);

    // Reset while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; mx = 8'h5A; my = 8'h3C;
    step();
    mx = 8'h11; my = 8'h22;
    step();
    chk("rstfull.in_ready", in_ready, 0);
    in_valid = 1'b0;
    RST = 1'b1;
    step();
    check_zero("rstfull");
    RST = 1'b0;
    step();
    chk("rstfull.release.in_ready", in_ready, 1);
    chk("rstfull.release.out_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstfull.no_stale", out_valid, 0);
    end

    // Randomized traffic against the queue model.
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 40000) begin
      chk("rnd.out_valid", out_valid, mq.size() > 0);
      chk("rnd.in_ready", in_ready, mq.size() < 2);
      if (mq.size() > 0) begin
        check_out("rnd", mq[0]);
        chk("rnd.decode", decode(), int'(mq[0].mx));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mx = 8'($urandom);
      my = 8'($urandom);
      can_push = (mq.size() < 2);
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (in_valid && can_push) begin
        ea = ref_model(mx, my);
        mq.push_back(ea);
        acc++;
      end
      step();
      cyc++;
    end
    chk("rnd.accepted", acc, 10000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (mq.size() > 0) begin
        chk("drain.out_valid", out_valid, 1);
        check_out("drain", mq[0]);
        void'(mq.pop_front());
      end
      step();
    end
    chk("drain.model_empty", mq.size(), 0);
    chk("drain.out_valid_low", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
